// File: rtl/status_led_pkg.sv
// rtl/status_led_pkg.sv - state encodings and derived divisor functions for status_led
package status_led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   // clocks per blink half-period (red on, then red off)
   function automatic int blink_half(input int clk_freq, input int blink_hz);
      return clk_freq / (2 * blink_hz);
   endfunction

   // clocks per one-step change of the breathing duty
   function automatic int breathe_step(input int clk_freq, input int pwm_bits);
      return clk_freq / (1 << (pwm_bits + 1));
   endfunction

endpackage

// File: rtl/status_led_if.sv
// rtl/status_led_if.sv - status inputs and LED/debug outputs of status_led
interface status_led_if;
   logic       i_running;
   logic       i_passed;
   logic       o_led_r;
   logic       o_led_g;
   logic       o_led_b;
   logic [1:0] o_state;

   modport master (
      output i_running, i_passed,
      input  o_led_r, o_led_g, o_led_b, o_state
   );

   modport slave (
      input  i_running, i_passed,
      output o_led_r, o_led_g, o_led_b, o_state
   );
endinterface

// File: rtl/status_led_led_pwm.sv
// rtl/status_led_led_pwm.sv - one PWM colour channel with a registered lit bit
module led_pwm #(
   parameter int PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [PWM_BITS-1:0] i_cnt,
   input  logic [PWM_BITS-1:0] i_duty,
   input  logic                i_en,
   output logic                o_lit
);
   logic r_lit;

   // duty 0 can never satisfy cnt < duty, so it is always dark
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lit <= 1'b0;
      end else begin
         r_lit <= i_en && (i_cnt < i_duty);
      end
   end

   assign o_lit = r_lit;
endmodule

// File: rtl/status_led.sv
// rtl/status_led.sv - test-status FSM driving PWM RGB LED patterns; STATUS_LED_BREATHE_EN breathes blue in RUN
module status_led
   import status_led_pkg::*;
#(
   parameter int CLK_FREQ = 48_000_000,
   parameter int PWM_BITS = 8,
   parameter int BRIGHT   = 64,
   parameter int BLINK_HZ = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   status_led_if.slave io
);
   localparam int BLINK_HALF = blink_half(CLK_FREQ, BLINK_HZ);
   localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);
   localparam logic [PWM_BITS-1:0] DUTY_BRIGHT = PWM_BITS'(BRIGHT);

`ifndef SYNTHESIS
   if (BLINK_HALF < 2) begin : g_chk_blink
      $error("status_led: CLK_FREQ/(2*BLINK_HZ) must be at least 2");
   end
   if (breathe_step(CLK_FREQ, PWM_BITS) < 1) begin : g_chk_step
      $error("status_led: CLK_FREQ/2^(PWM_BITS+1) must be at least 1");
   end
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [BLINK_W-1:0]  r_blink_cnt;
   logic                r_blink_ph;
   logic                w_enter_fail;
   logic [PWM_BITS-1:0] w_run_duty;
   logic                w_en_r, w_en_g, w_en_b;
   logic                w_lit_r, w_lit_g, w_lit_b;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (io.i_running) w_state_nxt = ST_RUN;
         ST_RUN:  if (!io.i_running) w_state_nxt = io.i_passed ? ST_PASS : ST_FAIL;
         ST_PASS: if (io.i_running) w_state_nxt = ST_RUN;
         ST_FAIL: if (io.i_running) w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_enter_fail = (w_state_nxt == ST_FAIL) && (r_state != ST_FAIL);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_pwm_cnt   <= '0;
         r_blink_cnt <= '0;
         r_blink_ph  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         // restart the blink so a fresh failure always opens with red on
         if (w_enter_fail) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
         end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

`ifdef STATUS_LED_BREATHE_EN
   localparam int BR_STEP = breathe_step(CLK_FREQ, PWM_BITS);
   localparam int BR_W    = (BR_STEP > 1) ? $clog2(BR_STEP) : 1;
   localparam logic [BR_W-1:0]     BR_LAST     = BR_W'(BR_STEP - 1);
   localparam logic [PWM_BITS-1:0] DUTY_NEAR_T = {{(PWM_BITS-1){1'b1}}, 1'b0};
   localparam logic [PWM_BITS-1:0] DUTY_ONE    = PWM_BITS'(1);

   logic [BR_W-1:0]     r_br_cnt;
   logic [PWM_BITS-1:0] r_br_duty;
   logic                r_br_down;
   logic                w_enter_run;

   assign w_enter_run = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);

   // triangle wave: turn around as the duty reaches full scale or zero
   always_ff @(posedge i_clk) begin
      if (i_rst || w_enter_run) begin
         r_br_cnt  <= '0;
         r_br_duty <= '0;
         r_br_down <= 1'b0;
      end else if (r_state == ST_RUN) begin
         if (r_br_cnt == BR_LAST) begin
            r_br_cnt <= '0;
            if (!r_br_down) begin
               r_br_duty <= r_br_duty + 1'b1;
               if (r_br_duty == DUTY_NEAR_T) r_br_down <= 1'b1;
            end else begin
               r_br_duty <= r_br_duty - 1'b1;
               if (r_br_duty == DUTY_ONE) r_br_down <= 1'b0;
            end
         end else begin
            r_br_cnt <= r_br_cnt + 1'b1;
         end
      end
   end

   assign w_run_duty = r_br_duty;
`else
   assign w_run_duty = DUTY_BRIGHT;
`endif

   assign w_en_r = (r_state == ST_FAIL) && r_blink_ph;
   assign w_en_g = (r_state == ST_PASS);
   assign w_en_b = (r_state == ST_RUN);

   led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_r (
      .i_clk(i_clk), .i_rst(i_rst), .i_cnt(r_pwm_cnt),
      .i_duty(DUTY_BRIGHT), .i_en(w_en_r), .o_lit(w_lit_r)
   );
   led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_g (
      .i_clk(i_clk), .i_rst(i_rst), .i_cnt(r_pwm_cnt),
      .i_duty(DUTY_BRIGHT), .i_en(w_en_g), .o_lit(w_lit_g)
   );
   led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_b (
      .i_clk(i_clk), .i_rst(i_rst), .i_cnt(r_pwm_cnt),
      .i_duty(w_run_duty), .i_en(w_en_b), .o_lit(w_lit_b)
   );

   assign io.o_led_r = w_lit_r;
   assign io.o_led_g = w_lit_g;
   assign io.o_led_b = w_lit_b;
   assign io.o_state = r_state;
endmodule
